// File: rtl/rom_rd_pkg.sv
// Shared definitions for the monitor-ROM read controller: FSM state
// encoding, the largest supported ROM read latency and the width of the
// latency down-counter derived from it.
package rom_rd_pkg;

  // Controller states: waiting for a request, waiting out the ROM latency,
  // presenting the captured byte until the CPU ends the cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } rom_rd_state_e;

  // Deepest ROM pipeline supported (output register enabled).
  localparam int ROM_LATENCY_MAX = 2;

  // The counter is loaded with the latency and counts down to zero.
  localparam int CNT_W = $clog2(ROM_LATENCY_MAX + 1);

  typedef logic [CNT_W-1:0] rom_rd_cnt_t;

  // Load value for the latency counter. Out-of-range latencies are pulled
  // into the supported range so the counter can never wrap.
  function automatic rom_rd_cnt_t latency_to_cnt(input int lat);
    int clamped;
    clamped = lat;
    if (clamped < 1) begin
      clamped = 1;
    end
    if (clamped > ROM_LATENCY_MAX) begin
      clamped = ROM_LATENCY_MAX;
    end
    return rom_rd_cnt_t'(clamped);
  endfunction

endpackage

// File: rtl/rom_read_ctrl.sv
// Bus-side read controller for the on-chip monitor ROM.
// Decodes CPU memory reads in the ROM window, registers the ROM address,
// holds the CPU in wait for the ROM latency, then captures the byte and
// presents it (qualified by rom_sel) until the CPU drops its strobes.
// Optional feature macro: ROM_SHADOW_EN -- when defined, a rom_disable pulse
// switches the ROM window off until the next reset; when undefined the window
// is always decoded and rom_disable is ignored.
module rom_read_ctrl
  import rom_rd_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 14,
  parameter int          DATA_WIDTH     = 8,
  parameter int          CPU_ADDR_WIDTH = 16,
  parameter int unsigned ROM_BASE       = 32'h0000_C000,
  parameter int          ROM_LATENCY    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_mreq,
  input  logic                  cpu_rd,
  input  logic                  rom_disable,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  cpu_wait,
  output logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic                  rom_sel,
  output logic                  rom_enabled
);

  localparam int TAG_W = CPU_ADDR_WIDTH - ADDR_WIDTH;
  localparam logic [CPU_ADDR_WIDTH-1:0] BASE_VEC = CPU_ADDR_WIDTH'(ROM_BASE);
  localparam logic [TAG_W-1:0] BASE_TAG = BASE_VEC[CPU_ADDR_WIDTH-1:ADDR_WIDTH];
  localparam rom_rd_cnt_t LAT_CNT = latency_to_cnt(ROM_LATENCY);

  rom_rd_state_e           state_reg, state_next;
  rom_rd_cnt_t             cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   data_reg, data_next;
  logic                    strobe;
  logic                    in_window;
  logic                    hit;
  logic                    wait_next;
  logic                    sel_next;

  // A read cycle is only live while both strobes are held.
  assign strobe    = cpu_mreq & cpu_rd;
  assign in_window = (cpu_addr[CPU_ADDR_WIDTH-1:ADDR_WIDTH] == BASE_TAG);
  // Reset masks the decode so cpu_wait drops the moment reset rises, even
  // though the CPU may still be holding its strobes.
  assign hit       = strobe & rom_enabled & in_window & ~reset;

`ifdef ROM_SHADOW_EN
  logic enabled_reg;

  // Shadow latch: one disable pulse switches the window off until reset.
  // Hits are only sampled in IDLE, so an in-flight access is unaffected.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enabled_reg <= 1'b1;
    end else if (rom_disable) begin
      enabled_reg <= 1'b0;
    end
  end

  assign rom_enabled = enabled_reg;
`else
  logic unused_rom_disable;

  assign unused_rom_disable = rom_disable;
  assign rom_enabled        = 1'b1;
`endif

  // State, latency counter, ROM address and captured byte registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
    end
  end

  // Next-state, datapath load enables and the wait/select outputs.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    wait_next  = 1'b0;
    sel_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Wait goes up in the same cycle the request shows up.
        if (hit) begin
          wait_next  = 1'b1;
          addr_next  = cpu_addr[ADDR_WIDTH-1:0];
          cnt_next   = LAT_CNT;
          state_next = FETCH;
        end
      end
      FETCH: begin
        wait_next = 1'b1;
        // An abandoned cycle never captures, so rom_sel cannot rise on it.
        if (!strobe) begin
          state_next = IDLE;
        end else if (cnt_reg == '0) begin
          data_next  = rom_data;
          state_next = HOLD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      HOLD: begin
        // Address changes here are ignored; only the strobes end the cycle.
        sel_next = 1'b1;
        if (!strobe) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign cpu_wait     = wait_next;
  assign rom_sel      = sel_next;
  assign rom_address  = addr_reg;
  assign cpu_data_out = data_reg;

endmodule

// File: tb/tb_rom_read_ctrl.sv
// Self-checking bench for rom_read_ctrl. Two instances (ROM latency 1 and 2)
// share the CPU stimulus; each has its own ROM model. Expected per-cycle
// outputs come from a transaction-level model: for a read held h cycles the
// wait/select windows and captured data follow from the latency arithmetic.
module tb_rom_read_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_mreq = 1'b0;
  logic        cpu_rd = 1'b0;
  logic        rom_disable = 1'b0;

  logic [13:0] rom_address1, rom_address2;
  logic [7:0]  rom_data1 = 8'h00;
  logic [7:0]  rom_data2 = 8'h00;
  logic [7:0]  rom_q2 = 8'h00;
  logic [7:0]  data_out1, data_out2;
  logic        wait1, wait2, sel1, sel2, en1, en2;

  logic [7:0]  mem [0:16383];

  int n_err = 0;
  int n_checks = 0;
  int txn = 0;

  logic [13:0] m_addr [2];
  logic [7:0]  m_data [2];
  logic        m_en;

`ifdef ROM_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  always #5 clock = ~clock;

  // ROM models: latency 1 = synchronous read, latency 2 = extra output register.
  always @(posedge clock) begin
    rom_data1 <= mem[rom_address1];
    rom_q2    <= mem[rom_address2];
    rom_data2 <= rom_q2;
  end

  rom_read_ctrl #(.ROM_LATENCY(1)) u_lat1 (
    .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_mreq(cpu_mreq),
    .cpu_rd(cpu_rd), .rom_disable(rom_disable), .rom_address(rom_address1),
    .rom_data(rom_data1), .cpu_wait(wait1), .cpu_data_out(data_out1),
    .rom_sel(sel1), .rom_enabled(en1)
  );

  rom_read_ctrl #(.ROM_LATENCY(2)) u_lat2 (
    .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_mreq(cpu_mreq),
    .cpu_rd(cpu_rd), .rom_disable(rom_disable), .rom_address(rom_address2),
    .rom_data(rom_data2), .cpu_wait(wait2), .cpu_data_out(data_out2),
    .rom_sel(sel2), .rom_enabled(en2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare one instance's outputs against expected values.
  task automatic check_dut(input int i, input string ctx, input logic w, input logic s,
                           input logic e, input logic [13:0] a, input logic [7:0] d);
    check_val($sformatf("%s wait L%0d", ctx, i + 1), (i == 0) ? wait1 : wait2, w);
    check_val($sformatf("%s sel L%0d", ctx, i + 1), (i == 0) ? sel1 : sel2, s);
    check_val($sformatf("%s en L%0d", ctx, i + 1), (i == 0) ? en1 : en2, e);
    check_val($sformatf("%s addr L%0d", ctx, i + 1), (i == 0) ? rom_address1 : rom_address2, a);
    check_val($sformatf("%s data L%0d", ctx, i + 1), (i == 0) ? data_out1 : data_out2, d);
  endtask

  // One bus transaction. op: 0 read, 1 write (mreq only), 2 rd without mreq.
  // Strobes are high for h cycles, low for gap cycles; kd = disable pulse cycle.
  task automatic do_read(input logic [15:0] a, input int op, input int h, input int gap,
                         input int kd);
    bit hit;
    bit en0;
    int waits1;
    int sels1;
    hit = (op == 0) && (a[15:14] == 2'b11) && m_en;
    en0 = m_en;
    waits1 = 0;
    sels1 = 0;
    for (int k = 0; k < h + gap; k++) begin
      @(posedge clock);
      #1;
      cpu_mreq    = (k < h) && (op != 2);
      cpu_rd      = (k < h) && (op != 1);
      cpu_addr    = (k == 0 || !hit) ? a : 16'($urandom);
      rom_disable = (k == kd);
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        int  lat;
        bit  full;
        bit  exp_w;
        bit  exp_s;
        bit  exp_e;
        lat   = i + 1;
        full  = (h >= lat + 2);
        exp_w = hit && (full ? (k <= lat + 1) : (k <= h));
        exp_s = hit && full && (k >= lat + 2) && (k <= h);
        exp_e = SHADOW ? (en0 && !(kd >= 0 && k > kd)) : 1'b1;
        if (hit && k == 1) m_addr[i] = a[13:0];
        if (hit && full && k == lat + 2) m_data[i] = mem[a[13:0]];
        check_dut(i, $sformatf("txn%0d k%0d", txn, k), exp_w, exp_s, exp_e, m_addr[i], m_data[i]);
      end
      if (wait1) waits1++;
      if (sel1 && k < h) sels1++;
    end
    if (SHADOW && kd >= 0) m_en = 1'b0;
    $display("txn %0d op=%0d addr=%h hold=%0d gap=%0d dis=%0d hit=%0d waitL1=%0d selL1=%0d dataL1=%h dataL2=%h",
             txn, op, a, h, gap, kd, hit, waits1, sels1, data_out1, data_out2);
    txn++;
  endtask

  // Start a read, then assert reset in the middle of the first FETCH cycle.
  task automatic do_reset_fetch(input logic [15:0] a);
    @(posedge clock);
    #1;
    cpu_mreq = 1'b1;
    cpu_rd   = 1'b1;
    cpu_addr = a;
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) check_dut(i, $sformatf("rst%0d async", txn), 1'b0, 1'b0, 1'b1, 14'h0, 8'h00);
    @(posedge clock);
    #1;
    cpu_mreq = 1'b0;
    cpu_rd   = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) check_dut(i, $sformatf("rst%0d held", txn), 1'b0, 1'b0, 1'b1, 14'h0, 8'h00);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0;
      m_data[i] = '0;
    end
    m_en = 1'b1;
    $display("txn %0d reset during fetch of addr=%h", txn, a);
    txn++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < 16384; j++) mem[j] = 8'($urandom);
    mem[0] = 8'h5A;
    mem[5] = 8'hA5;
    mem[6] = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0;
      m_data[i] = '0;
    end
    m_en = 1'b1;

    repeat (2) @(negedge clock);
    for (int i = 0; i < 2; i++) check_dut(i, "reset", 1'b0, 1'b0, 1'b1, 14'h0, 8'h00);
    #1;
    reset = 1'b0;

    // Directed cases
    do_read(16'hC005, 0, 6, 2, -1);  // basic read, 0xA5
    do_read(16'h8005, 0, 6, 2, -1);  // outside the window
    do_read(16'hBFFF, 0, 5, 1, -1);  // just below the window
    do_read(16'hC005, 1, 4, 1, -1);  // write is never decoded
    do_read(16'hC005, 2, 4, 1, -1);  // rd without mreq
    do_read(16'hC004, 0, 2, 1, -1);  // strobe dropped in second FETCH cycle
    do_read(16'hC006, 0, 5, 1, -1);  // next read returns mem[6]
    do_read(16'hFFFF, 0, 4, 1, -1);  // top of window, minimal full hold for L2
    do_read(16'hC001, 0, 1, 1, -1);  // abort after one cycle
    do_read(16'hC000, 0, 6, 1, 4);   // disable pulse during HOLD
    do_read(16'hC000, 0, 6, 1, -1);  // window off only with shadow enabled
    do_reset_fetch(16'hC003);
    do_read(16'hC000, 0, 6, 1, -1);  // works again after reset
    do_reset_fetch(16'hC00A);
    do_read(16'hC00A, 0, 5, 2, -1);  // first read after reset

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      int r;
      int op;
      int h;
      int kd;
      logic [15:0] a;
      r  = $urandom_range(0, 9);
      op = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
      if ($urandom_range(0, 3) != 0) a = {2'b11, 14'($urandom)};
      else a = {2'($urandom_range(0, 2)), 14'($urandom)};
      h  = $urandom_range(1, 7);
      kd = ($urandom_range(0, 15) == 0) ? $urandom_range(0, h - 1) : -1;
      if (n % 25 == 24) do_reset_fetch(a);
      else do_read(a, op, h, $urandom_range(1, 3), kd);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
